rot_frame_sched: RTL and testbench

Frame scheduler for the rotary-decoder telemetry link. On a programmable period it snapshots all channel counters and serialises one frame to the shared uart_tx: header, counter bytes, checksum. It sequences uart_tx byte by byte with a start/busy handshake and flags missed frame slots. It sits between the decoder1 instances and uart_tx, replacing the ad-hoc byte sequencing in the top level.

---
 rtl/rot_frame_sched_pkg.sv | 16 +
 rtl/rot_frame_sched_tx_byte_hs.sv | 62 ++++++
 rtl/rot_frame_sched.sv | 148 ++++++++++++++
 tb/tb_rot_frame_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_frame_sched_pkg.sv
// Shared types and constants for the rotary telemetry frame scheduler.
// Optional sequence byte is enabled by defining ROT_FRAME_SEQ_EN.
package rot_frame_pkg;

    typedef enum logic [2:0] {IDLE, SNAP, REQ, ACKD, NEXT} state_t;

    localparam logic [7:0] DEF_HEADER = 8'h5A;

    // Total bytes per frame: header, optional sequence byte, counter bytes, checksum.
    function automatic int unsigned frame_len(input int unsigned num_ch,
                                              input int unsigned cnt_bits,
                                              input bit          seq_en);
        return (seq_en ? 32'd3 : 32'd2) + (num_ch * cnt_bits) / 8;
    endfunction

endpackage

// File: rtl/rot_frame_sched_tx_byte_hs.sv
// Single-byte start/busy handshake towards uart_tx.
// The byte is latched on i_go and held until the transfer completes;
// tx_start is withheld while uart_tx is still busy from a previous byte.
module tx_byte_hs
    import rot_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_go,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_done
);

    state_t     r_state;
    logic       r_start;
    logic [7:0] r_data;
    logic       r_done;

    // Handshake sequencer: REQ holds start until busy is seen, ACKD waits for busy to fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_go) begin
                        r_data  <= i_byte;
                        r_start <= ~i_tx_busy;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (!r_start) begin
                        if (!i_tx_busy) r_start <= 1'b1;
                    end else if (i_tx_busy) begin
                        r_start <= 1'b0;
                        r_state <= ACKD;
                    end
                end
                ACKD: begin
                    if (!i_tx_busy) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tx_start = r_start;
    assign o_tx_data  = r_data;
    assign o_done     = r_done;

endmodule

// File: rtl/rot_frame_sched.sv
// Frame scheduler: snapshots channel counters once per slot and serialises
// header, counter bytes (channel 0 first, LSB first) and an 8-bit checksum.
// Define ROT_FRAME_SEQ_EN to insert a rolling sequence byte after the header.
module rot_frame_sched
    import rot_frame_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_BITS = 24,
    parameter int unsigned PERIOD   = 256,
    parameter logic [7:0]  HEADER   = DEF_HEADER
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       frame_tick,
    input  logic [NUM_CH*CNT_BITS-1:0] cnt_bus,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       overrun_clr
);

`ifdef ROT_FRAME_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif
    localparam int unsigned FLEN   = frame_len(NUM_CH, CNT_BITS, SEQ_EN);
    localparam int unsigned NBYTES = (NUM_CH * CNT_BITS) / 8;
    localparam int unsigned DBASE  = SEQ_EN ? 2 : 1;

    state_t                      r_state;
    logic [15:0]                 r_slot;
    logic [NUM_CH*CNT_BITS-1:0]  r_snap;
    logic [7:0]                  r_cs;
    logic [5:0]                  r_idx;
    logic                        r_go;
    logic                        r_frame_done;
    logic                        r_overrun;
`ifdef ROT_FRAME_SEQ_EN
    logic [7:0]                  r_seq;
`endif

    logic       w_slot;
    logic       w_last;
    logic       w_is_data;
    logic [7:0] w_byte;
    logic       w_hs_done;

    assign w_slot    = enable & frame_tick & (r_slot == 16'(PERIOD - 1));
    assign w_last    = (r_idx == 6'(FLEN - 1));
    assign w_is_data = (r_idx != '0) && !w_last;

    // Byte for the current index; the checksum slot falls through to r_cs.
    always_comb begin
        w_byte = r_cs;
        if (r_idx == '0) w_byte = HEADER;
`ifdef ROT_FRAME_SEQ_EN
        if (r_idx == 6'd1) w_byte = r_seq;
`endif
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (r_idx == 6'(k + DBASE)) w_byte = r_snap[k*8 +: 8];
        end
    end

    // Slot counter paced by frame_tick; held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (!enable) begin
            r_slot <= '0;
        end else if (frame_tick) begin
            r_slot <= w_slot ? '0 : r_slot + 16'd1;
        end
    end

    // Frame sequencer; the byte handshake itself lives in tx_byte_hs (covers REQ/ACKD).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_snap       <= '0;
            r_cs         <= '0;
            r_idx        <= '0;
            r_go         <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef ROT_FRAME_SEQ_EN
            r_seq        <= '0;
`endif
        end else begin
            r_go         <= 1'b0;
            r_frame_done <= 1'b0;
            // A slot landing on the final NEXT cycle is dropped silently, not flagged.
            if (w_slot && (r_state != IDLE) && !((r_state == NEXT) && w_last))
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_slot) r_state <= SNAP;
                end
                SNAP: begin
                    r_snap  <= cnt_bus;
                    r_cs    <= '0;
                    r_idx   <= '0;
                    r_go    <= 1'b1;
                    r_state <= REQ;
                end
                REQ: begin
                    if (w_hs_done) r_state <= NEXT;
                end
                NEXT: begin
                    if (w_is_data) r_cs <= r_cs + w_byte;
                    if (w_last) begin
                        r_frame_done <= 1'b1;
                        r_idx        <= '0;
`ifdef ROT_FRAME_SEQ_EN
                        r_seq        <= r_seq + 8'd1;
`endif
                        r_state      <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 6'd1;
                        r_go    <= 1'b1;
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    tx_byte_hs u_hs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_go       (r_go),
        .i_byte     (w_byte),
        .i_tx_busy  (tx_busy),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_done     (w_hs_done)
    );

    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_rot_frame_sched.sv
// Directed bench for rot_frame_sched with a uart_tx busy responder.
// Covers the ROT_FRAME_SEQ_EN build as well when that macro is defined.
module tb_rot_frame_sched;

`ifdef ROT_FRAME_SEQ_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        frame_tick = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        ext_busy = 1'b0;
    logic        mdl_busy = 1'b0;
    logic [71:0] cnt_bus = '0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_done;
    logic        overrun;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;
    int unsigned stab_err = 0;
    int unsigned busy_len = 1;
    logic [7:0]  cap[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq = 8'h00;

    assign tx_busy = ext_busy | mdl_busy;

    always #10 clk = ~clk;

    rot_frame_sched #(.PERIOD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .cnt_bus     (cnt_bus),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // uart_tx stand-in: accepts a byte on tx_start, stays busy for busy_len clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !tx_busy) begin
                cap.push_back(tx_data);
                mdl_busy = 1'b1;
                repeat (busy_len) begin
                    @(negedge clk);
                    if (tx_data !== cap[$]) stab_err++;
                end
                mdl_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) if (frame_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_exp(input logic [71:0] cnt);
        logic [7:0] cs;
        exp_q.delete();
        exp_q.push_back(8'h5A);
        cs = 8'h00;
`ifdef ROT_FRAME_SEQ_EN
        exp_q.push_back(exp_seq);
        cs = exp_seq;
`endif
        for (int b = 0; b < 9; b++) begin
            exp_q.push_back(cnt[b*8 +: 8]);
            cs = cs + cnt[b*8 +: 8];
        end
        exp_q.push_back(cs);
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s_b%0d", tag, i), cap[i], exp_q[i]);
    endtask

    // Four consecutive ticks: exactly one slot wrap at PERIOD=4.
    task automatic slot(input bit with_clr);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        overrun_clr = with_clr;
        @(negedge clk);
        frame_tick  = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic wait_done(input bit scramble);
        int unsigned start;
        start = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == start; i++) begin
            @(negedge clk);
            if (scramble) cnt_bus = 72'({$urandom, $urandom, $urandom});
        end
        if (done_cnt == start) check("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt - start, 1);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        int unsigned hi;
        int unsigned d0;
        logic [71:0] snap;
        bit seen;

        #25;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Basic frame with hand-computed bytes, checksum 0x2D.
        cnt_bus = {24'h090807, 24'h060504, 24'h030201};
        exp_q.delete();
        exp_q.push_back(8'h5A);
`ifdef ROT_FRAME_SEQ_EN
        exp_q.push_back(8'h00);
`endif
        for (int b = 1; b <= 9; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'h2D);
        cap.delete();
        slot(0);
        wait_done(0);
        cmp_frame("basic");

        // Long busy: data held stable, no lost or duplicated bytes.
        busy_len = 20;
        stab_err = 0;
        cnt_bus  = {24'h800000, 24'h000001, 24'hFFFFFF};
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        wait_done(0);
        cmp_frame("busy20");
        check("busy20_stable", stab_err, 0);
        busy_len = 1;

        // uart_tx already busy when the frame starts: tx_start must wait.
        ext_busy = 1'b1;
        cnt_bus  = {24'h123456, 24'h789ABC, 24'hDEF012};
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        hi = 0;
        repeat (15) begin
            @(negedge clk);
            if (tx_start) hi++;
        end
        check("start_while_busy", hi, 0);
        ext_busy = 1'b0;
        wait_done(0);
        cmp_frame("prebusy");

        // Snapshot isolation: cnt_bus scrambled every clk after the SNAP cycle.
        busy_len = 2;
        cnt_bus  = {24'hA5A5A5, 24'h5A5A5A, 24'hC3C3C3};
        snap     = cnt_bus;
        build_exp(snap);
        cap.delete();
        slot(0);
        wait_done(1);
        cmp_frame("snapiso");

        // Overrun: slot while a frame is in flight, frame stays intact.
        busy_len = 3;
        cnt_bus  = {24'h000102, 24'h030405, 24'h060708};
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        repeat (10) @(negedge clk);
        slot(0);
        check("ovr_set", overrun, 1);
        wait_done(0);
        cmp_frame("ovr_frame");
        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Slot event and clear in the same cycle: set wins.
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        repeat (10) @(negedge clk);
        check("ovr_pre_setwins", overrun, 0);
        slot(1);
        check("ovr_setwins", overrun, 1);
        wait_done(0);
        cmp_frame("setwins_frame");
        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        busy_len = 1;

        // enable dropped mid-frame: frame completes, no further frames.
        cnt_bus = {24'h111111, 24'h222222, 24'h333333};
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_done(0);
        cmp_frame("en_fall");
        d0 = done_cnt;
        slot(0);
        slot(0);
        repeat (40) @(negedge clk);
        check("disabled_no_bytes", cap.size(), FLEN);
        check("disabled_no_done", done_cnt, d0);
        check("disabled_no_ovr", overrun, 0);
        enable = 1'b1;

        // Asynchronous reset while byte 5 is being requested.
        busy_len = 4;
        cnt_bus  = {24'h445566, 24'h778899, 24'hAABBCC};
        cap.delete();
        slot(0);
        for (int i = 0; i < 500 && cap.size() < 5; i++) @(negedge clk);
        check("rst_reach_b5", cap.size(), 5);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!tx_start && !tx_busy) seen = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (tx_start) seen = 1'b1;
        end
        check("rst_b5_start", tx_start, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_start", tx_start, 0);
        check("rst_async_data", tx_data, 0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        exp_seq  = 8'h00;
        busy_len = 1;
        build_exp(cnt_bus);
        cap.delete();
        slot(0);
        wait_done(0);
        cmp_frame("after_rst");
        check("after_rst_hdr", (cap.size() > 0) ? cap[0] : 8'h00, 8'h5A);

`ifdef ROT_FRAME_SEQ_EN
        // Sequence byte counts 00..FF then wraps to 00, 01.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_seq = 8'h00;
        for (int f = 0; f < 258; f++) begin
            cnt_bus = 72'({$urandom, $urandom, $urandom});
            build_exp(cnt_bus);
            cap.delete();
            slot(0);
            wait_done(0);
            check($sformatf("seq_f%0d", f), (cap.size() > 1) ? cap[1] : 8'hxx, 8'(f));
            cmp_frame($sformatf("seqframe%0d", f));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
